// File: rtl/nor4_response_checker.sv
// Exhaustive 4-input NOR/OR response checker: walks all 16 stimulus vectors,
// lets each settle, samples the gate response and records mismatch statistics.
module nor4_response_checker #(
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter bit          INVERT        = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_out,
  output logic       outA,
  output logic       outB,
  output logic       outC,
  output logic       outD,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] first_fail_vec,
  output logic       first_fail_valid
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [4:0] ERR_MAX     = 5'd16;

  logic [1:0] state_q, state_d;
  logic [3:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] err_q, err_d;
  logic [3:0] ffv_q, ffv_d;
  logic       ffvalid_q, ffvalid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       expected;
  logic       mismatch;

  always_comb begin
    expected  = INVERT ? ~(|vec_q) : (|vec_q);
    mismatch  = (dut_out != expected);

    state_d   = state_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    ffv_d     = ffv_q;
    ffvalid_d = ffvalid_q;
    busy_d    = busy_q;
    done_d    = done_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Results and vec=15 hold in DONE until a new run is requested.
        if (start) begin
          state_d   = ST_SETTLE;
          vec_d     = 4'd0;
          cnt_d     = 4'd0;
          err_d     = 5'd0;
          ffv_d     = 4'd0;
          ffvalid_d = 1'b0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) begin
            err_d = err_q + 5'd1;
          end
          if (!ffvalid_q) begin
            ffv_d     = vec_q;
            ffvalid_d = 1'b1;
          end
        end
        // The last vector ends the run without wrapping the stimulus.
        if (vec_q == 4'hF) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_SETTLE;
          vec_d   = vec_q + 4'd1;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      vec_q     <= 4'd0;
      cnt_q     <= 4'd0;
      err_q     <= 5'd0;
      ffv_q     <= 4'd0;
      ffvalid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign outA             = vec_q[3];
  assign outB             = vec_q[2];
  assign outC             = vec_q[1];
  assign outD             = vec_q[0];
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = done_q & (err_q == 5'd0);
  assign err_count        = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_nor4_response_checker.sv
// Bench for nor4_response_checker: a NOR-expecting and an OR-expecting instance
// each drive a configurable faulty gate model; results are predicted per vector.
module tb_nor4_response_checker;

  localparam int S0 = 3;
  localparam int S1 = 1;

  logic clk = 1'b0;
  logic rst_n;
  logic start;

  logic       a0, b0, c0, d0, busy0, done0, pass0, ffval0, r0;
  logic [4:0] err0;
  logic [3:0] ffv0;
  logic       a1, b1, c1, d1, busy1, done1, pass1, ffval1, r1;
  logic [4:0] err1;
  logic [3:0] ffv1;

  // Gate models: 0 = NOR, 1 = OR, 2 = stuck 0, 3 = stuck 1, XOR a per-vector flip mask.
  int          mode0, mode1;
  logic [15:0] flip0, flip1;

  int checks = 0;
  int errors = 0;
  int ne0, f0, ne1, f1;

  always #5 clk = ~clk;

  nor4_response_checker #(.SETTLE_CYCLES(S0), .INVERT(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_out(r0),
    .outA(a0), .outB(b0), .outC(c0), .outD(d0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_fail_vec(ffv0), .first_fail_valid(ffval0)
  );

  nor4_response_checker #(.SETTLE_CYCLES(S1), .INVERT(1'b0)) u_dut_or (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_out(r1),
    .outA(a1), .outB(b1), .outC(c1), .outD(d1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_vec(ffv1), .first_fail_valid(ffval1)
  );

  function automatic logic gate(int mode, logic [15:0] flip, logic [3:0] v);
    logic base;
    case (mode)
      0:       base = (v == 4'd0);
      1:       base = (v != 4'd0);
      2:       base = 1'b0;
      default: base = 1'b1;
    endcase
    return base ^ flip[v];
  endfunction

  always_comb r0 = gate(mode0, flip0, {a0, b0, c0, d0});
  always_comb r1 = gate(mode1, flip1, {a1, b1, c1, d1});

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Predict error count and first failing vector of a full run.
  task automatic model(int mode, logic [15:0] flip, bit inv, output int ne, output int first);
    logic e;
    ne    = 0;
    first = -1;
    for (int v = 0; v < 16; v++) begin
      e = inv ? (v == 0) : (v != 0);
      if (gate(mode, flip, v[3:0]) != e) begin
        ne++;
        if (first < 0) first = v;
      end
    end
  endtask

  task automatic run(string tag, int repulse_at, bit hold_start);
    int lat0, lat1;
    logic [4:0] e0s, e1s;
    logic [3:0] fv0s, fv1s, v0s, v1s;
    logic p0s, p1s, fl0s, fl1s, b0s, b1s;
    model(mode0, flip0, 1'b1, ne0, f0);
    model(mode1, flip1, 1'b0, ne1, f1);
    start = 1'b1;
    tick();
    if (!hold_start) start = 1'b0;
    chk({tag, "_busy_start"}, busy0, 1);
    chk({tag, "_done_start"}, done0, 0);
    chk({tag, "_vec_start"}, {a0, b0, c0, d0}, 0);
    lat0 = 0;
    lat1 = 0;
    for (int n = 1; n <= 200 && (lat0 == 0 || lat1 == 0); n++) begin
      if (n == repulse_at) start = 1'b1;
      tick();
      if (n == repulse_at && !hold_start) start = 1'b0;
      if (lat0 == 0 && done0 === 1'b1) begin
        lat0 = n; e0s = err0; fv0s = ffv0; p0s = pass0; fl0s = ffval0; b0s = busy0;
        v0s = {a0, b0, c0, d0};
      end
      if (lat1 == 0 && done1 === 1'b1) begin
        lat1 = n; e1s = err1; fv1s = ffv1; p1s = pass1; fl1s = ffval1; b1s = busy1;
        v1s = {a1, b1, c1, d1};
      end
    end
    chk({tag, "_lat0"}, lat0, 16 * (S0 + 1));
    chk({tag, "_lat1"}, lat1, 16 * (S1 + 1));
    if (lat0 != 0) begin
      chk({tag, "_err0"}, e0s, ne0);
      chk({tag, "_pass0"}, p0s, (ne0 == 0));
      chk({tag, "_ffval0"}, fl0s, (f0 >= 0));
      chk({tag, "_ffv0"}, fv0s, (f0 >= 0) ? f0 : 0);
      chk({tag, "_vec0"}, v0s, 15);
      chk({tag, "_busy0"}, b0s, 0);
    end
    if (lat1 != 0) begin
      chk({tag, "_err1"}, e1s, ne1);
      chk({tag, "_pass1"}, p1s, (ne1 == 0));
      chk({tag, "_ffval1"}, fl1s, (f1 >= 0));
      chk({tag, "_ffv1"}, fv1s, (f1 >= 0) ? f1 : 0);
      chk({tag, "_vec1"}, v1s, 15);
      chk({tag, "_busy1"}, b1s, 0);
    end
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_i0"}, {a0, b0, c0, d0, busy0, done0, pass0, err0, ffv0, ffval0}, 0);
    chk({tag, "_i1"}, {a1, b1, c1, d1, busy1, done1, pass1, err1, ffv1, ffval1}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode0 = 0; flip0 = 16'h0;
    mode1 = 1; flip1 = 16'h0;
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();
    tick();
    chk_all_zero("idle_wait");

    // Correct gates on both instances.
    run("clean", 0, 1'b0);
    repeat (5) tick();
    chk("hold_done", done0, 1);
    chk("hold_vec", {a0, b0, c0, d0}, 15);
    chk("hold_pass", pass0, 1);
    chk("hold_err", err0, ne0);

    // Stuck-at 0 on the NOR checker; NOR gate on the OR checker.
    mode0 = 2; mode1 = 0;
    run("stuck0", 0, 1'b0);
    chk("stuck0_err_const", err0, 1);
    chk("or_vs_nor_err_const", err1, 16);

    // Stuck-at 1 on the NOR checker; stuck-at 0 on the OR checker.
    mode0 = 3; mode1 = 2;
    run("stuck1", 0, 1'b0);
    chk("stuck1_ffv_const", ffv0, 1);
    chk("stuck1_err_const", err0, 15);

    // Start re-pulsed mid-run must be ignored.
    mode0 = 0; mode1 = 1;
    flip0 = 16'($urandom); flip1 = 16'($urandom);
    run("repulse", 20, 1'b0);

    for (int i = 0; i < 4; i++) begin
      mode0 = $urandom_range(0, 3);
      mode1 = $urandom_range(0, 3);
      flip0 = 16'($urandom) & 16'($urandom);
      flip1 = 16'($urandom) & 16'($urandom);
      run("rand", 0, 1'b0);
    end

    // Continuous start: restart on the first cycle in DONE.
    mode0 = 0; flip0 = 16'h0; mode1 = 1; flip1 = 16'h0;
    run("hold_start", 0, 1'b1);
    tick();
    chk("restart_busy", busy0, 1);
    chk("restart_done", done0, 0);
    chk("restart_vec", {a0, b0, c0, d0}, 0);
    chk("restart_err", err0, 0);
    start = 1'b0;

    // Reset mid-run discards partial results.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    mode0 = 3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    chk("midrun_busy", busy0, 1);
    // Vectors 0..6 sampled so far; stuck-at 1 fails all but vector 0.
    chk("midrun_err", err0, 6);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    tick();
    chk_all_zero("reset_held");
    rst_n = 1'b1;
    tick();
    tick();
    chk_all_zero("post_reset_idle");
    mode0 = 0;
    run("after_reset", 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
